// File: rtl/z80_dma_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// z80_dma_writer_if : control and byte-stream handshake for z80_dma_writer
// Revision 1.0
// ---------------------------------------------------------------------------
interface z80_dma_writer_if;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] length;
  logic        abort;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;

  modport master (
    output start, start_addr, length, abort, data_in, data_valid,
    input  data_ready, busy, done
  );

  modport slave (
    input  start, start_addr, length, abort, data_in, data_valid,
    output data_ready, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/z80_dma_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// z80_dma_writer : Z80 bus master writing a byte stream into Z80 memory
// Revision 1.0
// ---------------------------------------------------------------------------
module z80_dma_writer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  z80_dma_writer_if.slave  ctl,
  input  wire logic        BusAck,
  output logic             BusRQ,
  inout  wire       [15:0] Address,
  inout  wire       [7:0]  Memory,
  inout  wire              Z80_MEMrq,
  inout  wire              Z80_WR,
  inout  wire              Z80_RD
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_OWN     = 3'd2;
  localparam logic [2:0] S_FETCH   = 3'd3;
  localparam logic [2:0] S_SETUP   = 3'd4;
  localparam logic [2:0] S_STROBE  = 3'd5;
  localparam logic [2:0] S_HOLD    = 3'd6;
  localparam logic [2:0] S_RELEASE = 3'd7;

  localparam logic [3:0] c_setup_last  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_strobe_last = 4'(STROBE_CYC - 1);
  localparam logic [3:0] c_hold_last   = 4'(HOLD_CYC - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_addr;
  logic [15:0] r_rem;
  logic [7:0]  r_data;
  logic        r_abort;
  logic        r_done;
  logic        r_ack_s1;
  logic        r_ack_s2;

  logic        w_abort_any;
  logic        w_take;
  logic        w_accept;
  logic        w_done_next;
  logic        w_own;
  logic        w_drive_data;
  logic        w_strobe;
  logic        w_busrq;
  logic        w_ready;

  assign w_abort_any = r_abort | ctl.abort;
  assign w_accept    = (r_state == S_IDLE) && ctl.start && (ctl.length != 16'd0);
  assign w_take      = (r_state == S_FETCH) && !w_abort_any && ctl.data_valid;

  // State register and datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= 16'd0;
      r_rem    <= 16'd0;
      r_data   <= 8'd0;
      r_abort  <= 1'b0;
      r_done   <= 1'b0;
      r_ack_s1 <= 1'b1;
      r_ack_s2 <= 1'b1;
    end else begin
      r_ack_s1 <= BusAck;
      r_ack_s2 <= r_ack_s1;
      r_state  <= w_next;
      r_cnt    <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
      r_done   <= w_done_next;
      r_abort  <= (r_state == S_IDLE) ? 1'b0 : w_abort_any;
      if (w_accept) begin
        r_addr <= ctl.start_addr;
        r_rem  <= ctl.length;
      end
      if (w_take) begin
        r_data <= ctl.data_in;
      end
      if ((r_state == S_HOLD) && (w_next != S_HOLD)) begin
        r_addr <= r_addr + 16'd1;
        r_rem  <= r_rem - 16'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next      = r_state;
    w_done_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_REQ;
        end
        w_done_next = ctl.start && (ctl.length == 16'd0);
      end
      S_REQ: begin
        if (w_abort_any) begin
          // Already granted: the bus must be handed back cleanly via RELEASE
          w_next      = r_ack_s2 ? S_IDLE : S_RELEASE;
          w_done_next = r_ack_s2;
        end else if (!r_ack_s2) begin
          w_next = S_OWN;
        end
      end
      S_OWN: w_next = S_FETCH;
      S_FETCH: begin
        if (w_abort_any) begin
          w_next = S_RELEASE;
        end else if (ctl.data_valid) begin
          w_next = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == c_setup_last) begin
          w_next = S_STROBE;
        end
      end
      S_STROBE: begin
        if (r_cnt == c_strobe_last) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == c_hold_last) begin
          w_next = ((r_rem == 16'd1) || w_abort_any) ? S_RELEASE : S_FETCH;
        end
      end
      S_RELEASE: begin
        w_next      = S_IDLE;
        w_done_next = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_own        = 1'b0;
    w_drive_data = 1'b0;
    w_strobe     = 1'b0;
    w_busrq      = 1'b1;
    w_ready      = 1'b0;
    case (r_state)
      S_REQ: w_busrq = 1'b0;
      S_OWN: begin
        w_own   = 1'b1;
        w_busrq = 1'b0;
      end
      S_FETCH: begin
        w_own   = 1'b1;
        w_busrq = 1'b0;
        w_ready = !w_abort_any;
      end
      S_SETUP, S_HOLD: begin
        w_own        = 1'b1;
        w_busrq      = 1'b0;
        w_drive_data = 1'b1;
      end
      S_STROBE: begin
        w_own        = 1'b1;
        w_busrq      = 1'b0;
        w_drive_data = 1'b1;
        w_strobe     = 1'b1;
      end
      S_RELEASE: begin
        w_own   = 1'b1;
        w_busrq = 1'b0;
      end
      default: ;
    endcase
  end

  assign ctl.data_ready = w_ready;
  assign ctl.busy       = (r_state != S_IDLE);
  assign ctl.done       = r_done;
  assign BusRQ          = w_busrq;

  assign Address   = w_own        ? r_addr    : 16'bz;
  assign Memory    = w_drive_data ? r_data    : 8'bz;
  assign Z80_MEMrq = w_own        ? !w_strobe : 1'bz;
  assign Z80_WR    = w_own        ? !w_strobe : 1'bz;
  assign Z80_RD    = w_own        ? 1'b1      : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_z80_dma_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_z80_dma_writer : directed scoreboard bench for z80_dma_writer
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_z80_dma_writer;
  localparam int SETUP_CYC  = 2;
  localparam int STROBE_CYC = 4;
  localparam int HOLD_CYC   = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic BusAck  = 1'b1;
  wire  BusRQ;
  // Pulls make a released bus observable: Z reads as all-ones, RD as zero
  tri1 [15:0] Address;
  tri1 [7:0]  Memory;
  tri1        Z80_MEMrq;
  tri1        Z80_WR;
  tri0        Z80_RD;

  z80_dma_writer_if ctl ();

  z80_dma_writer #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ctl      (ctl.slave),
    .BusAck   (BusAck),
    .BusRQ    (BusRQ),
    .Address  (Address),
    .Memory   (Memory),
    .Z80_MEMrq(Z80_MEMrq),
    .Z80_WR   (Z80_WR),
    .Z80_RD   (Z80_RD)
  );

  always #5 clk = ~clk;

  // Z80 side: grant the bus three cycles after BUSRQ falls
  int rq_cnt = 0;
  always @(negedge clk) begin
    if (BusRQ === 1'b0) begin
      rq_cnt = rq_cnt + 1;
      if (rq_cnt >= 3) BusAck = 1'b0;
    end else begin
      rq_cnt = 0;
      BusAck = 1'b1;
    end
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  pat[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp = n_cmp + 1;
    assert (obs === expv) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_write(input logic [15:0] a, input logic [7:0] d, input int len, input logic bad);
    logic [23:0] e;
    chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("write_addr", 32'(a), 32'(e[23:8]));
      chk("write_data", 32'(d), 32'(e[7:0]));
      chk("strobe_len", 32'(len), 32'(STROBE_CYC));
      chk("strobe_stable", 32'(bad), 32'd0);
    end
  endtask

  task automatic check_released(input string tag);
    chk({tag, "_busrq"}, 32'(BusRQ), 32'd1);
    chk({tag, "_rd_z"}, 32'(Z80_RD), 32'd0);
    chk({tag, "_memrq_z"}, 32'(Z80_MEMrq), 32'd1);
    chk({tag, "_wr_z"}, 32'(Z80_WR), 32'd1);
    chk({tag, "_addr_z"}, 32'(Address), 32'h0000_FFFF);
    chk({tag, "_mem_z"}, 32'(Memory), 32'h0000_00FF);
    chk({tag, "_busy"}, 32'(ctl.busy), 32'd0);
  endtask

  // One transfer: abort_byte / rst_byte select a strobe index for abort or reset (-1 = none)
  task automatic xfer(input logic [15:0] a, input logic [15:0] n, input int gap,
                      input int abort_byte, input int rst_byte);
    int nexp, idx, gap_left, done_cnt, done_cyc, s_len, s_num;
    logic pend, in_strobe, s_bad, rq_seen, own_seen, finished;
    logic [15:0] s_addr;
    logic [7:0]  s_data;
    nexp = (rst_byte >= 0) ? rst_byte : (abort_byte >= 0) ? abort_byte + 1 : int'(n);
    for (int i = 0; i < nexp; i++) exp_q.push_back({a + 16'(i), pat[i]});
    idx = 0; gap_left = 0; done_cnt = 0; done_cyc = -1; s_len = 0; s_num = -1;
    pend = 0; in_strobe = 0; s_bad = 0; rq_seen = 0; own_seen = 0; finished = 0;
    s_addr = '0; s_data = '0;
    @(negedge clk);
    ctl.start = 1'b1; ctl.start_addr = a; ctl.length = n;
    @(negedge clk);
    ctl.start = 1'b0;
    for (int cyc = 1; cyc < 2000 && !finished; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (ctl.abort) ctl.abort = 1'b0;
      if (done_cyc >= 0) begin
        chk("done_width", 32'(ctl.done), 32'd0);
        finished = 1;
      end else begin
        if (BusRQ === 1'b0) rq_seen = 1;
        if (Z80_RD === 1'b1) own_seen = 1;
        if (Z80_MEMrq === 1'b0) begin
          if (!in_strobe) begin
            in_strobe = 1; s_len = 0; s_bad = 0; s_num++;
            s_addr = Address; s_data = Memory;
          end
          s_len++;
          if (Address !== s_addr || Memory !== s_data || Z80_WR !== 1'b0) s_bad = 1;
          if (s_len == 2 && s_num == abort_byte) ctl.abort = 1'b1;
          if (s_len == 2 && s_num == rst_byte) begin
            #2 reset_n = 1'b0;
            #1 check_released("async_rst");
            ctl.data_valid = 1'b0;
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            chk("rst_no_write", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            return;
          end
        end else if (in_strobe) begin
          in_strobe = 0;
          check_write(s_addr, s_data, s_len, s_bad);
        end else if (Z80_WR === 1'b0) begin
          s_bad = 1;
        end
        if (ctl.done) begin
          done_cnt++;
          done_cyc = cyc;
          check_released("release");
        end
        if (pend) begin
          idx++; gap_left = gap; pend = 0;
        end
        if (gap_left > 0) begin
          ctl.data_valid = 1'b0; gap_left--;
        end else if (idx < int'(n)) begin
          ctl.data_valid = 1'b1; ctl.data_in = pat[idx];
        end else begin
          ctl.data_valid = 1'b0;
        end
        #1 pend = ctl.data_valid && ctl.data_ready;
      end
    end
    ctl.data_valid = 1'b0;
    chk("finished_in_budget", 32'(finished), 32'd1);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("missing_writes", 32'(exp_q.size()), 32'd0);
    chk("busrq_used", 32'(rq_seen), 32'(n != 16'd0));
    chk("bus_owned", 32'(own_seen), 32'(n != 16'd0));
    if (n == 16'd0) chk("len0_done_cycle", 32'(done_cyc), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    ctl.start = 1'b0; ctl.start_addr = '0; ctl.length = '0; ctl.abort = 1'b0;
    ctl.data_in = '0; ctl.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_ready", 32'(ctl.data_ready), 32'd0);
    chk("rst_done", 32'(ctl.done), 32'd0);
    check_released("reset");
    reset_n = 1'b1;

    pat[0] = 8'hA5;
    xfer(16'h4000, 16'd1, 0, -1, -1);

    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    xfer(16'h8000, 16'd4, 3, -1, -1);

    pat[0] = 8'h5A; pat[1] = 8'hC3;
    xfer(16'hFFFF, 16'd2, 0, -1, -1);

    xfer(16'h1234, 16'd0, 0, -1, -1);

    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h03; pat[3] = 8'h04; pat[4] = 8'h05;
    xfer(16'h3000, 16'd5, 1, 1, -1);

    pat[0] = 8'h77; pat[1] = 8'h78; pat[2] = 8'h79;
    xfer(16'h2000, 16'd3, 0, -1, 0);

    pat[0] = 8'h9C;
    xfer(16'h5000, 16'd1, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/z80_dma_writer.md
Name: z80_dma_writer

Overview:
- Z80 bus master that writes a block of bytes into Z80 memory. It is the counterpart to the passive IO-write address snooper.
- It asserts BusRQ and waits for BusAck. It then drives memory write cycles on Address/Memory/Z80_MEMrq/Z80_WR, taking bytes from an internal byte-stream source (FujiNet response buffer).
- When the block completes it releases the bus.

Parameters:
SETUP_CYC, 2, clk cycles Address/Memory are driven before MEMrq/WR fall (1..15)
STROBE_CYC, 4, clk cycles MEMrq and WR are held low (1..15)
HOLD_CYC, 2, clk cycles Address/Memory stay driven after MEMrq/WR rise (1..15)

Ports:
clk  input  1  system clock (single domain)
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latches start_addr and length when idle
start_addr  input  16  first Z80 memory address
length  input  16  byte count (0 = no transfer)
abort  input  1  finish the current byte, then release the bus
data_in  input  8  next byte to write
data_valid  input  1  data_in valid
data_ready  output  1  byte consumed this cycle when data_valid&data_ready
busy  output  1  high from accepted start until bus released
done  output  1  one-cycle pulse at completion or abort
BusAck  input  1  Z80 BUSACK, active low, asynchronous
BusRQ  output  1  Z80 BUSRQ, active low
Address  inout  16  Z80 address bus; driven only when owned, else Z
Memory  inout  8  Z80 data bus; driven only during write, else Z
Z80_MEMrq  inout  1  driven when owned (high idle, low strobe), else Z
Z80_WR  inout  1  driven when owned, else Z
Z80_RD  inout  1  driven high when owned, else Z

Behaviour:
- Reset values: BusRQ=1, data_ready=0, busy=0, done=0. Address, Memory, Z80_MEMrq, Z80_WR and Z80_RD are all Z. State = IDLE, counters = 0.
- BusAck passes through a 2-flop synchronizer. All decisions use the synced value.
- IDLE:
  - start with length≠0 → latch addr/len, busy=1, go to REQ.
  - start with length=0 → done pulse next cycle, busy stays 0, BusRQ stays 1.
  - start while busy is ignored.
- REQ: BusRQ=0. Wait for synced BusAck=0, then go to OWN. No timeout.
- OWN (1 cycle): drive Z80_MEMrq=1, Z80_WR=1, Z80_RD=1 and Address=current addr. Go to FETCH.
- FETCH:
  - data_ready=1. On data_valid, capture the byte and go to SETUP.
  - If abort is seen before capture, go to RELEASE.
  - While waiting, the bus stays owned with strobes high.
- SETUP: drive Memory=byte. Hold SETUP_CYC cycles, then go to STROBE.
- STROBE: Z80_MEMrq=0 and Z80_WR=0 for STROBE_CYC cycles. Both fall on the same edge and rise on the same edge. Then go to HOLD.
- HOLD:
  - Strobes high, address/data held for HOLD_CYC cycles.
  - Then addr+=1 (16-bit wrap FFFF→0000) and remaining-=1.
  - If remaining=0 or abort was latched, go to RELEASE; else go to FETCH.
- RELEASE (1 cycle): strobes high, Memory=Z.
- Next cycle:
  - Tristate every bus signal and set BusRQ=1.
  - Pulse done for 1 cycle, busy=0, return to IDLE.
  - Bus signals must not go Z while Z80_MEMrq or Z80_WR is low.
- Abort is sticky once seen while busy. It never truncates a strobe in progress.
- Abort during REQ: deassert BusRQ and pulse done. If BusAck is already synced low, pass through RELEASE instead.
- Per-byte cycle: SETUP_CYC+STROBE_CYC+HOLD_CYC clk cycles plus ≥1 FETCH cycle.
- Z80_RD is never driven low.
- Asynchronous reset mid-transfer immediately tristates the bus and deasserts BusRQ. No cycle completes.

Test Plan:
- Single byte: start_addr=0x4000, length=1, byte 0xA5, BusAck low 3 cycles after BusRQ → exactly one WR strobe of 4 clk at 0x4000 with Memory=0xA5 stable across strobe; bus Z then BusRQ=1, done pulse once.
- Block of 4 bytes 0x11,0x22,0x33,0x44 at 0x8000 with data_valid gaps of 3 cycles → writes at 0x8000..0x8003 in order; strobes stay high during gaps.
- Wrap: start_addr=0xFFFF, length=2 → writes at 0xFFFF then 0x0000.
- length=0 → done next cycle; BusRQ never low; bus never driven.
- Abort asserted mid-STROBE of byte 2 of 5 → byte 2 completes with full 4-clk strobe, no byte 3; release and done follow.
- reset_n low during STROBE → same-cycle (asynchronous) Address/Memory/MEMrq/WR = Z, BusRQ=1; after release a new start works normally.
